alu: RTL and testbench

- Registered integer ALU for the single-cycle processor datapath; one operation selected by a 5-bit function code.
- func[4]=0 selects arithmetic/logic ops that produce dataOut. func[4]=1 selects comparison ops that produce the branch flag compTrue.
- Results are registered: one clock of latency from operands to outputs.

---
 rtl/alu.sv | 74 +++++++
 tb/tb_alu.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// rtl/alu.sv - registered integer ALU with arithmetic, logic and signed compare ops
// Optional shifter ops compiled in when ALU_SHIFT_EN is defined.
module alu #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4:0]           func,
  input  logic [BIT_WIDTH-1:0] dataIn1,
  input  logic [BIT_WIDTH-1:0] dataIn2,
  output logic [BIT_WIDTH-1:0] dataOut,
  output logic                 compTrue
);

`ifdef ALU_SHIFT_EN
  localparam int SHW = $clog2(BIT_WIDTH);
`endif

  logic [BIT_WIDTH-1:0] data_d, data_q;
  logic                 comp_d, comp_q;
  logic                 a_lt_b, a_eq_b;

  assign a_lt_b = $signed(dataIn1) < $signed(dataIn2);
  assign a_eq_b = dataIn1 == dataIn2;

  always_comb begin
    data_d = '0;
    comp_d = 1'b0;
    case (func)
      5'b00000: data_d = dataIn1 + dataIn2;
      5'b00001: data_d = dataIn1 - dataIn2;
      5'b00100: data_d = dataIn1 & dataIn2;
      5'b00101: data_d = dataIn1 | dataIn2;
      5'b00110: data_d = dataIn1 ^ dataIn2;
      5'b01100: data_d = ~(dataIn1 & dataIn2);
      5'b01101: data_d = ~(dataIn1 | dataIn2);
      5'b01110: data_d = ~(dataIn1 ^ dataIn2);
`ifdef ALU_SHIFT_EN
      // Only the low clog2(BIT_WIDTH) bits of B form the shift amount.
      5'b01000: data_d = dataIn1 << dataIn2[SHW-1:0];
      5'b01001: data_d = dataIn1 >> dataIn2[SHW-1:0];
      5'b01010: data_d = $signed(dataIn1) >>> dataIn2[SHW-1:0];
`endif
      5'b10000: comp_d = 1'b0;
      5'b10001: comp_d = a_eq_b;
      5'b10010: comp_d = a_lt_b;
      5'b10011: comp_d = a_lt_b | a_eq_b;
      5'b11000: comp_d = 1'b1;
      5'b11001: comp_d = ~a_eq_b;
      5'b11010: comp_d = ~a_lt_b;
      5'b11011: comp_d = ~(a_lt_b | a_eq_b);
      default: begin
        data_d = '0;
        comp_d = 1'b0;
      end
    endcase
    // Compare ops mirror the flag onto the data bus, zero-extended.
    if (func[4]) data_d = {{(BIT_WIDTH-1){1'b0}}, comp_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      comp_q <= 1'b0;
    end else begin
      data_q <= data_d;
      comp_q <= comp_d;
    end
  end

  assign dataOut  = data_q;
  assign compTrue = comp_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu; shift expectations follow ALU_SHIFT_EN
module tb_alu;

  logic        clk;
  logic        reset_n;
  logic [4:0]  func;
  logic [31:0] dataIn1;
  logic [31:0] dataIn2;
  logic [31:0] dataOut;
  logic        compTrue;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        c;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;

  alu #(.BIT_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .func    (func),
    .dataIn1 (dataIn1),
    .dataIn2 (dataIn2),
    .dataOut (dataOut),
    .compTrue(compTrue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act_d, input logic act_c,
                       input logic [31:0] exp_d, input logic exp_c);
    n_vec++;
    if (act_d !== exp_d || act_c !== exp_c) begin
      n_err++;
      $display("FAIL %s: got dataOut=%h compTrue=%b, want dataOut=%h compTrue=%b",
               name, act_d, act_c, exp_d, exp_c);
    end
  endtask

  task automatic apply(input string name, input logic [4:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ed, input logic ec);
    exp_t e;
    @(negedge clk);
    func    = f;
    dataIn1 = a;
    dataIn2 = b;
    e.name = name;
    e.d    = ed;
    e.c    = ec;
    sb_q.push_back(e);
  endtask

  // Monitor: every edge that follows a pushed vector produces exactly one result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, dataOut, compTrue, e.d, e.c);
    end
  end

  initial begin
    exp_t e;
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b1;
    func    = 5'b00000;
    dataIn1 = 32'd1;
    dataIn2 = 32'd1;

    // Load a nonzero result, then pull reset between edges.
    @(posedge clk);
    #1;
    check("pre_reset_add", dataOut, compTrue, 32'd2, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", dataOut, compTrue, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    apply("add_2_3",      5'b00000, 32'd2, 32'd3, 32'd5, 1'b0);
    apply("sub_5_2",      5'b00001, 32'd5, 32'd2, 32'd3, 1'b0);
    apply("sub_wrap",     5'b00001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    apply("add_wrap",     5'b00000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    apply("eq_true",      5'b10001, 32'd2, 32'd2, 32'd1, 1'b1);
    apply("eq_false",     5'b10001, 32'd2, 32'd3, 32'd0, 1'b0);
    apply("ne_true",      5'b11001, 32'd2, 32'd3, 32'd1, 1'b1);
    apply("lt_signed",    5'b10010, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b1);
    apply("gt_signed",    5'b11011, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0);
    apply("lte_signed",   5'b10011, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b1);
    apply("gte_equal",    5'b11010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1);
    apply("lt_equal",     5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
    apply("gt_pos_neg",   5'b11011, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 1'b1);
    apply("f_const",      5'b10000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0);
    apply("t_const",      5'b11000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b1);
    apply("and",          5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    apply("or",           5'b00101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    apply("xor",          5'b00110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    apply("nand",         5'b01100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 1'b0);
    apply("nor",          5'b01101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0);
    apply("xnor",         5'b01110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF00F_F00F, 1'b0);
    apply("illegal_1f",   5'b11111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0);
    apply("illegal_02",   5'b00010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0);
    apply("b2b_add",      5'b00000, 32'd100, 32'd23, 32'd123, 1'b0);
    apply("b2b_sub",      5'b00001, 32'd100, 32'd23, 32'd77, 1'b0);
`ifdef ALU_SHIFT_EN
    apply("sra",          5'b01010, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    apply("srl",          5'b01001, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    apply("sll_upper_b",  5'b01000, 32'd1, 32'h0000_0024, 32'h0000_0010, 1'b0);
`else
    apply("sra_off",      5'b01010, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
    apply("srl_off",      5'b01001, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
    apply("sll_off",      5'b01000, 32'd1, 32'h0000_0024, 32'd0, 1'b0);
`endif

    // Func changed mid-cycle: only the value present at the edge counts.
    apply("mid_cycle_func", 5'b00100, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_0FFF, 1'b0);
    #2;
    func = 5'b00101;

    // Reset asserted across the edge discards the pending ADD.
    @(negedge clk);
    func    = 5'b00000;
    dataIn1 = 32'd9;
    dataIn2 = 32'd9;
    e.name = "reset_discard";
    e.d    = 32'd0;
    e.c    = 1'b0;
    sb_q.push_back(e);
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    apply("post_reset_add", 5'b00000, 32'd9, 32'd9, 32'd18, 1'b0);

    repeat (3) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results still pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
